// File: rtl/nv_ram_fifo_pkg.sv
// Shared constants and helpers for the 160x65 RAM FIFO controller.
// Imported by the controller, its skid buffer and the RAM model.
package nv_ram_fifo_pkg;

    localparam int DEPTH      = 160;
    localparam int AW         = 8;
    localparam int DW         = 65;
    localparam int SKID_DEPTH = 3;
    localparam int CW         = 8;
    localparam int SCW        = $clog2(SKID_DEPTH + 1);

    // DEPTH is not a power of two, so the wrap must be explicit.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/nv_ram_fifo_skid.sv
// Small register FIFO that absorbs RAM read data in flight.
// Push and pop in the same cycle are allowed even when full.
module nv_ram_fifo_skid
    import nv_ram_fifo_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [DW-1:0]  din,
    output logic [DW-1:0]  dout,
    output logic [SCW-1:0] cnt
);

    logic [DW-1:0]  mem [SKID_DEPTH];
    logic [SCW-1:0] head;
    logic [SCW-1:0] tail;

    function automatic logic [SCW-1:0] sinc(input logic [SCW-1:0] p);
        return (p == SCW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= din;
                tail      <= sinc(tail);
            end
            if (pop) begin
                head <= sinc(head);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout = mem[head];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && cnt == SCW'(SKID_DEPTH)));

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && cnt == '0));

endmodule

// File: rtl/nv_ram_rwsp_160x65.sv
// Behavioural 160x65 two-port RAM: registered read address,
// output register loaded only when ore is high.
module nv_ram_rwsp_160x65
    import nv_ram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic [AW-1:0] ra,
    input  logic          re,
    input  logic          ore,
    output logic [DW-1:0] dout,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [DW-1:0] di
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= di;
        end
        if (re) begin
            ra_q <= ra;
        end
        if (ore) begin
            dout <= mem[ra_q];
        end
    end

endmodule

// File: rtl/nv_ram_rwsp_160x65_fifo_ctrl.sv
// Valid/ready FIFO built on the 160x65 two-port RAM; the 2-cycle
// read latency is hidden behind a credit-managed skid buffer.
module nv_ram_rwsp_160x65_fifo_ctrl
    import nv_ram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic [31:0]   ram_pwrbus_ram_pd,
    output logic [CW-1:0] fifo_cnt,
    output logic          idle
);

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  ram_cnt;
    logic           s1_vld;
    logic           s2_vld;
    logic [SCW-1:0] skid_cnt;
    logic           wr_acc;
    logic           rd_issue;
    logic           pop;
    logic [2:0]     credit_use;

    assign wr_prdy = !reset && (ram_cnt < CW'(DEPTH));
    assign wr_acc  = wr_pvld && wr_prdy;
    assign rd_pvld = !reset && (skid_cnt != '0);
    assign pop     = rd_pvld && rd_prdy;

    // Skid slots already promised: held + in flight, less this pop.
    assign credit_use = 3'(skid_cnt) + 3'(s1_vld) + 3'(s2_vld) - 3'(pop);
    assign rd_issue   = !reset && (ram_cnt != '0)
                      && (credit_use < 3'(SKID_DEPTH));

    assign ram_we  = wr_acc;
    assign ram_wa  = wr_ptr;
    assign ram_di  = wr_pd;
    assign ram_re  = rd_issue;
    assign ram_ra  = rd_ptr;
    assign ram_ore = !reset && s1_vld;

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_issue) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({wr_acc, rd_issue})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
            s1_vld <= rd_issue;
            s2_vld <= s1_vld;
        end
    end

    nv_ram_fifo_skid u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (s2_vld),
        .pop   (pop),
        .din   (ram_dout),
        .dout  (rd_pd),
        .cnt   (skid_cnt)
    );

    assign fifo_cnt = reset ? '0
                    : ram_cnt + CW'(s1_vld) + CW'(s2_vld) + CW'(skid_cnt);
    assign idle = (fifo_cnt == '0);

endmodule

// File: tb/tb_nv_ram_rwsp_160x65_fifo_ctrl.sv
// Directed bench for the RAM FIFO controller: vector table plus
// stream, fill/wrap, random and reset sequences with a scoreboard.
module tb_nv_ram_rwsp_160x65_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_pvld = 1'b0;
    logic        wr_prdy;
    logic [64:0] wr_pd = '0;
    logic        rd_pvld;
    logic        rd_prdy = 1'b0;
    logic [64:0] rd_pd;
    logic [7:0]  ram_wa;
    logic        ram_we;
    logic [64:0] ram_di;
    logic [7:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic [64:0] ram_dout;
    logic [31:0] pwrbus_ram_pd = 32'hA5A5_0F0F;
    logic [31:0] ram_pwrbus_ram_pd;
    logic [7:0]  fifo_cnt;
    logic        idle;

    always #5 clk = ~clk;

    nv_ram_rwsp_160x65_fifo_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_ore           (ram_ore),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd),
        .fifo_cnt          (fifo_cnt),
        .idle              (idle)
    );

    nv_ram_rwsp_160x65 u_ram (
        .clk  (clk),
        .ra   (ram_ra),
        .re   (ram_re),
        .ore  (ram_ore),
        .dout (ram_dout),
        .wa   (ram_wa),
        .we   (ram_we),
        .di   (ram_di)
    );

    typedef struct {
        logic        rst;
        logic        wv;
        logic [64:0] d;
        logic        rp;
        logic        e_wrdy;
        logic        e_rvld;
        logic [64:0] e_pd;
        logic [7:0]  e_cnt;
        logic        e_we;
        logic        e_re;
        logic        e_ore;
    } vec_t;

    localparam logic [64:0] PA = 65'h1_DEAD_BEEF_0000_0001;
    localparam logic [64:0] PB = 65'h0_0000_0000_0000_AAAA;
    localparam logic [64:0] PC = 65'h1_0000_0000_0000_5555;

    vec_t        vt [15];
    logic [64:0] q [$];
    int          errors = 0;
    int          checks = 0;
    int          ore_bad = 0;
    int          cnt_bad = 0;
    int          npop = 0;
    logic        acc;
    logic        popd;
    logic        prev_re = 1'b0;
    int          sent;
    int          got;
    int          first;
    int          gaps;
    int          cyc_n;

    function automatic vec_t mk(input logic rst, input logic wv,
                                input logic [64:0] d, input logic rp,
                                input logic e_wrdy, input logic e_rvld,
                                input logic [64:0] e_pd,
                                input logic [7:0] e_cnt,
                                input logic e_we, input logic e_re,
                                input logic e_ore);
        vec_t v;
        v.rst = rst; v.wv = wv; v.d = d; v.rp = rp;
        v.e_wrdy = e_wrdy; v.e_rvld = e_rvld; v.e_pd = e_pd;
        v.e_cnt = e_cnt; v.e_we = e_we; v.e_re = e_re; v.e_ore = e_ore;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic wv,
                       input logic [64:0] d, input logic rp);
        logic [64:0] e;
        @(negedge clk);
        reset = r; wr_pvld = wv; wr_pd = d; rd_prdy = rp;
        #1;
        acc  = wr_pvld && wr_prdy;
        popd = rd_pvld && rd_prdy;
        if (!r && ram_ore !== prev_re) ore_bad++;
        if (fifo_cnt > 8'd163) cnt_bad++;
        prev_re = r ? 1'b0 : ram_re;
        if (r) q.delete();
        if (acc) q.push_back(d);
        if (popd) begin
            npop++;
            if (q.size() == 0) begin
                chk("underrun", 65'(rd_pvld), 65'd0);
            end else begin
                e = q.pop_front();
                chk("order", rd_pd, e);
            end
        end
    endtask

    initial begin
        vt[0]  = mk(1, 1, PA, 1, 0, 0, '0, 0, 0, 0, 0);
        vt[1]  = mk(1, 1, PA, 1, 0, 0, '0, 0, 0, 0, 0);
        vt[2]  = mk(0, 1, PA, 1, 1, 0, '0, 0, 1, 0, 0);
        vt[3]  = mk(0, 0, '0, 1, 1, 0, '0, 1, 0, 1, 0);
        vt[4]  = mk(0, 0, '0, 1, 1, 0, '0, 1, 0, 0, 1);
        vt[5]  = mk(0, 0, '0, 1, 1, 0, '0, 1, 0, 0, 0);
        vt[6]  = mk(0, 0, '0, 1, 1, 1, PA, 1, 0, 0, 0);
        vt[7]  = mk(0, 0, '0, 1, 1, 0, '0, 0, 0, 0, 0);
        vt[8]  = mk(0, 1, PB, 1, 1, 0, '0, 0, 1, 0, 0);
        vt[9]  = mk(0, 1, PC, 1, 1, 0, '0, 1, 1, 1, 0);
        vt[10] = mk(0, 0, '0, 1, 1, 0, '0, 2, 0, 1, 1);
        vt[11] = mk(0, 0, '0, 1, 1, 0, '0, 2, 0, 0, 1);
        vt[12] = mk(0, 0, '0, 1, 1, 1, PB, 2, 0, 0, 0);
        vt[13] = mk(0, 0, '0, 1, 1, 1, PC, 1, 0, 0, 0);
        vt[14] = mk(0, 0, '0, 1, 1, 0, '0, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            cyc(vt[i].rst, vt[i].wv, vt[i].d, vt[i].rp);
            chk($sformatf("v%0d wr_prdy", i), 65'(wr_prdy), 65'(vt[i].e_wrdy));
            chk($sformatf("v%0d rd_pvld", i), 65'(rd_pvld), 65'(vt[i].e_rvld));
            chk($sformatf("v%0d fifo_cnt", i), 65'(fifo_cnt), 65'(vt[i].e_cnt));
            chk($sformatf("v%0d idle", i), 65'(idle), 65'(vt[i].e_cnt == 0));
            chk($sformatf("v%0d ram_we", i), 65'(ram_we), 65'(vt[i].e_we));
            chk($sformatf("v%0d ram_re", i), 65'(ram_re), 65'(vt[i].e_re));
            chk($sformatf("v%0d ram_ore", i), 65'(ram_ore), 65'(vt[i].e_ore));
            if (vt[i].e_rvld) chk($sformatf("v%0d rd_pd", i), rd_pd, vt[i].e_pd);
        end
        chk("pwrbus", 65'(ram_pwrbus_ram_pd), 65'h0_A5A5_0F0F);

        // stream of 1000 words, sink always ready
        cyc(1, 0, '0, 1);
        sent = 0; got = npop; first = -1; gaps = 0;
        for (cyc_n = 0; cyc_n < 1100 && npop - got < 1000; cyc_n++) begin
            cyc(0, sent < 1000, 65'(sent), 1);
            if (acc) sent++;
            if (rd_pvld && first < 0) first = cyc_n;
            if (first >= 0 && !rd_pvld && npop - got < 1000) gaps++;
        end
        chk("stream first", 65'(first), 65'd4);
        chk("stream gaps", 65'(gaps), 65'd0);
        chk("stream count", 65'(npop - got), 65'd1000);

        // fill with sink stalled, then pop one and drain across wrap
        cyc(1, 0, '0, 0);
        sent = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(0, 1, {1'b1, 32'(sent), ~32'(sent)}, 0);
            if (acc) sent++;
            else break;
        end
        chk("fill accepted", 65'(sent), 65'd163);
        chk("fill fifo_cnt", 65'(fifo_cnt), 65'd163);
        cyc(0, 0, '0, 1);
        chk("full wr_prdy", 65'(wr_prdy), 65'd0);
        cyc(0, 0, '0, 0);
        chk("after pop wr_prdy", 65'(wr_prdy), 65'd1);
        chk("after pop fifo_cnt", 65'(fifo_cnt), 65'd162);
        for (int i = 0; i < 400 && (q.size() != 0 || fifo_cnt != 0); i++) begin
            cyc(0, 0, '0, 1);
        end
        chk("drain empty", 65'(q.size()), 65'd0);
        chk("drain idle", 65'(idle), 65'd1);

        // random traffic
        cyc(1, 0, '0, 0);
        sent = 0; got = npop;
        for (int i = 0; i < 30000 && npop - got < 5000; i++) begin
            cyc(0, sent < 5000 && $urandom_range(0, 1) == 1,
                {$urandom(), $urandom(), 1'b0} ^ 65'(sent),
                $urandom_range(0, 1) == 1);
            if (acc) sent++;
        end
        chk("random count", 65'(npop - got), 65'd5000);
        chk("ore follows re", 65'(ore_bad), 65'd0);
        chk("fifo_cnt bound", 65'(cnt_bad), 65'd0);

        // reset with reads in flight
        cyc(1, 0, '0, 0);
        for (int i = 0; i < 53; i++) cyc(0, 1, 65'(100 + i), 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 0);
        chk("pre-reset fifo_cnt", 65'(fifo_cnt), 65'd50);
        chk("pre-reset in flight", 65'(ram_ore), 65'd1);
        cyc(1, 1, 65'h7, 1);
        chk("in reset rd_pvld", 65'(rd_pvld), 65'd0);
        chk("in reset fifo_cnt", 65'(fifo_cnt), 65'd0);
        chk("in reset wr_prdy", 65'(wr_prdy), 65'd0);
        cyc(0, 1, 65'h5, 1);
        chk("post reset rd_pvld", 65'(rd_pvld), 65'd0);
        chk("post reset fifo_cnt", 65'(fifo_cnt), 65'd0);
        got = npop; first = -1;
        for (int i = 1; i < 12 && first < 0; i++) begin
            cyc(0, 0, '0, 1);
            if (rd_pvld) begin
                first = i;
                chk("post reset first word", rd_pd, 65'h5);
            end
        end
        chk("post reset latency", 65'(first), 65'd4);
        cyc(0, 0, '0, 1);
        chk("post reset no stale", 65'(rd_pvld), 65'd0);
        chk("ore follows re final", 65'(ore_bad), 65'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
